// File: rtl/at24c02_seq.sv
// AT24C02 transaction sequencer: turns one byte-level request into the i2c_master
// command/data sequence for a page write or a random read, with write-cycle wait.
module at24c02_seq #(
    parameter logic [6:0] DEV_ADDR      = 7'h50,
    parameter int         PAGE_BYTES    = 8,
    parameter int         WR_CYCLE_CLKS = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [2:0] req_len,
    input  logic [7:0] wr_tdata,
    input  logic       wr_tvalid,
    output logic       wr_tready,
    output logic [7:0] rd_tdata,
    output logic       rd_tvalid,
    input  logic       rd_tready,
    output logic       rd_tlast,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic [6:0] m_cmd_address,
    output logic       m_cmd_start,
    output logic       m_cmd_read,
    output logic       m_cmd_write,
    output logic       m_cmd_write_multiple,
    output logic       m_cmd_stop,
    output logic       m_cmd_valid,
    input  logic       m_cmd_ready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       missed_ack
);
    localparam int CW = (WR_CYCLE_CLKS > 1) ? $clog2(WR_CYCLE_CLKS) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(WR_CYCLE_CLKS - 1);

    typedef enum logic [3:0] {
        IDLE, WR_CMD, WR_ADDR, WR_DATA, WR_WAIT, RD_CMD_A, RD_ADDR, RD_CMD_R, FIN
    } state_t;

    state_t state, state_n;
    logic          wr_q, nack_q, rej_q, iss_done_q, rx_done_q;
    logic [7:0]    addr_q;
    logic [2:0]    len_q, cnt_q, rx_q;
    logic [CW-1:0] wait_q;
    logic          page_bad, rd_path, iss_fin, rx_fin;

    // i2c_master's tlast on the read stream carries nothing we need
    logic unused_s_tlast;
    assign unused_s_tlast = s_tlast;

    assign m_cmd_address = DEV_ADDR;
    assign page_bad = ({2'b00, req_addr[2:0]} + {2'b00, req_len} + 5'd1) > 5'(PAGE_BYTES);
    assign rd_path  = (state == RD_CMD_A) || (state == RD_ADDR) || (state == RD_CMD_R);
    assign iss_fin  = iss_done_q || (m_cmd_ready && cnt_q == len_q);
    assign rx_fin   = rx_done_q || (s_tvalid && rd_tready && rx_q == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            nack_q     <= 1'b0;
            rej_q      <= 1'b0;
            cnt_q      <= '0;
            rx_q       <= '0;
            iss_done_q <= 1'b0;
            rx_done_q  <= 1'b0;
            wait_q     <= '0;
        end else begin
            state <= state_n;
            if (state != IDLE && missed_ack) nack_q <= 1'b1;
            if (state == IDLE && req_valid) begin
                wr_q       <= req_write;
                addr_q     <= req_addr;
                len_q      <= req_len;
                nack_q     <= 1'b0;
                rej_q      <= req_write && page_bad;
                cnt_q      <= '0;
                rx_q       <= '0;
                iss_done_q <= 1'b0;
                rx_done_q  <= 1'b0;
            end
            if (state == WR_DATA && wr_tvalid && m_tready) cnt_q <= cnt_q + 3'd1;
            // counters stop at len and raise a done flag, so len=7 never wraps
            if (state == RD_CMD_R && !iss_done_q && m_cmd_ready) begin
                if (cnt_q == len_q) iss_done_q <= 1'b1;
                else                cnt_q      <= cnt_q + 3'd1;
            end
            if (s_tvalid && s_tready && !rx_done_q) begin
                if (rx_q == len_q) rx_done_q <= 1'b1;
                else               rx_q      <= rx_q + 3'd1;
            end
            if (state == WR_DATA)      wait_q <= WAIT_INIT;
            else if (state == WR_WAIT) wait_q <= wait_q - 1'b1;
        end
    end

    always_comb begin
        state_n              = state;
        req_ready            = 1'b0;
        wr_tready            = 1'b0;
        rd_tdata             = '0;
        rd_tvalid            = 1'b0;
        rd_tlast             = 1'b0;
        s_tready             = 1'b0;
        m_cmd_start          = 1'b0;
        m_cmd_read           = 1'b0;
        m_cmd_write          = 1'b0;
        m_cmd_write_multiple = 1'b0;
        m_cmd_stop           = 1'b0;
        m_cmd_valid          = 1'b0;
        m_tdata              = '0;
        m_tvalid             = 1'b0;
        m_tlast              = 1'b0;
        done                 = 1'b0;
        err                  = 1'b0;
        busy                 = (state != IDLE);
        if (rd_path) begin
            s_tready  = rd_tready;
            rd_tdata  = s_tdata;
            rd_tvalid = s_tvalid;
            rd_tlast  = (rx_q == len_q);
        end
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_n = !req_write ? RD_CMD_A : (page_bad ? FIN : WR_CMD);
            end
            WR_CMD: begin
                m_cmd_valid          = 1'b1;
                m_cmd_start          = 1'b1;
                m_cmd_write_multiple = 1'b1;
                m_cmd_stop           = 1'b1;
                if (m_cmd_ready) state_n = WR_ADDR;
            end
            WR_ADDR: begin
                m_tdata  = addr_q;
                m_tvalid = 1'b1;
                if (m_tready) state_n = WR_DATA;
            end
            WR_DATA: begin
                m_tdata   = wr_tdata;
                m_tvalid  = wr_tvalid;
                wr_tready = m_tready;
                m_tlast   = (cnt_q == len_q);
                // a NACKed write never started an internal cycle, so skip the wait
                if (wr_tvalid && m_tready && cnt_q == len_q)
                    state_n = (nack_q || missed_ack) ? FIN : WR_WAIT;
            end
            WR_WAIT: if (wait_q == '0) state_n = FIN;
            RD_CMD_A: begin
                m_cmd_valid          = 1'b1;
                m_cmd_start          = 1'b1;
                m_cmd_write_multiple = 1'b1;
                if (m_cmd_ready) state_n = RD_ADDR;
            end
            RD_ADDR: begin
                m_tdata  = addr_q;
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                if (m_tready) state_n = RD_CMD_R;
            end
            RD_CMD_R: begin
                m_cmd_valid = !iss_done_q;
                m_cmd_read  = 1'b1;
                m_cmd_start = (cnt_q == 3'd0);
                m_cmd_stop  = (cnt_q == len_q);
                if (iss_fin && rx_fin) state_n = FIN;
            end
            FIN: begin
                done    = 1'b1;
                err     = nack_q || rej_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_at24c02_seq.sv
// Directed bench for at24c02_seq: a request table run against a small i2c_master /
// EEPROM model, with reset checks and a reset-during-write-wait sequence.
module tb_at24c02_seq;
    localparam int WR = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr;
    logic [2:0] req_len;
    logic [7:0] wr_tdata, rd_tdata, m_tdata, s_tdata;
    logic       wr_tvalid, wr_tready, rd_tvalid, rd_tready, rd_tlast;
    logic       done, err, busy;
    logic [6:0] m_cmd_address;
    logic       m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop;
    logic       m_cmd_valid, m_cmd_ready;
    logic       m_tvalid, m_tready, m_tlast;
    logic       s_tvalid, s_tready, s_tlast, missed_ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    at24c02_seq #(.DEV_ADDR(7'h50), .PAGE_BYTES(8), .WR_CYCLE_CLKS(WR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
        .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tlast(rd_tlast),
        .done(done), .err(err), .busy(busy),
        .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
        .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple),
        .m_cmd_stop(m_cmd_stop), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .missed_ack(missed_ack)
    );

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [2:0] len;
        logic [63:0] data;      // payload (write) or slave bytes (read), byte i at [8i+:8]
        bit         nack;       // pulse missed_ack during the write address beat
        bit         stall;      // rd_tready low 10 cycles after the first read byte
        bit         mstall;     // cmd/stream readies toggle every cycle
        bit         rst_wait;   // assert rst during the write-cycle wait
        bit         exp_err;
        int         exp_ncmd;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] ctl_vec();
        return {m_cmd_valid, m_tvalid, s_tready, wr_tready, rd_tvalid, done, err, busy,
                m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop};
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wr_tdata = 0; wr_tvalid = 0; rd_tready = 1; m_cmd_ready = 1; m_tready = 1;
        s_tdata = 0; s_tvalid = 0; s_tlast = 0; missed_ack = 0;
    endtask

    task automatic run(input vec_t v);
        logic [7:0] q[$];
        logic [4:0] ebits;
        logic [7:0] eb;
        int ci = 0, mi = 0, ri = 0, wi = 0, cyc = 0, beat_cyc = -1, stall_left = 0, ndone = 0;
        bit fin = 0;
        int nm = (v.exp_ncmd == 0) ? 0 : (v.wr ? int'(v.len) + 2 : 1);
        @(negedge clk);
        req_valid = 1; req_write = v.wr; req_addr = v.addr; req_len = v.len;
        #1 chk("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        while (!fin && cyc < 400) begin
            m_cmd_ready = v.mstall ? cyc[0] : 1'b1;
            m_tready    = v.mstall ? ~cyc[0] : 1'b1;
            wr_tvalid   = v.wr && (wi <= int'(v.len));
            wr_tdata    = (wi < 8) ? v.data[8*wi +: 8] : 8'h00;
            s_tvalid    = (q.size() > 0);
            s_tdata     = (q.size() > 0) ? q[0] : 8'h00;
            rd_tready   = (stall_left == 0);
            missed_ack  = v.nack && ci == 1 && mi == 0;
            rst         = v.rst_wait && beat_cyc >= 0 && cyc == beat_cyc + 4;
            #1;
            if (rst) begin
                @(negedge clk);
                rst = 0;
                #1;
                chk("rst_abort_outputs", ctl_vec(), 0);
                chk("rst_abort_req_ready", req_ready, 1);
                for (int k = 0; k < WR + 5; k++) begin
                    @(negedge clk); #1;
                    if (done) ndone++;
                end
                chk("rst_abort_no_done", ndone, 0);
                idle_inputs();
                return;
            end
            if (cyc == 0) chk("busy", busy, 1);
            if (stall_left == 5 && !v.wr) chk("s_tready_stall", s_tready, 0);
            if (m_cmd_valid && m_cmd_ready) begin
                if (v.wr)         ebits = 5'b10011;
                else if (ci == 0) ebits = 5'b10010;
                else              ebits = {ci == 1, 1'b1, 1'b0, 1'b0, ci == int'(v.len) + 1};
                chk($sformatf("cmd%0d_bits", ci),
                    {m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop}, ebits);
                chk("cmd_addr", m_cmd_address, 7'h50);
                if (!v.wr && ci >= 1) q.push_back(v.data[8*(ci-1) +: 8]);
                ci++;
            end
            if (m_tvalid && m_tready) begin
                eb = (mi == 0) ? v.addr : v.data[8*(mi-1) +: 8];
                chk($sformatf("m_beat%0d", mi), {m_tlast, m_tdata},
                    {(v.wr ? (mi == int'(v.len) + 1) : (mi == 0)), eb});
                if (v.wr && m_tlast) beat_cyc = cyc;
                mi++;
            end
            if (wr_tvalid && wr_tready) wi++;
            if (stall_left > 0) stall_left--;
            if (rd_tvalid && rd_tready) begin
                chk($sformatf("rd_beat%0d", ri), {rd_tlast, rd_tdata},
                    {ri == int'(v.len), v.data[8*ri +: 8]});
                void'(q.pop_front());
                ri++;
                if (v.stall && ri == 1) stall_left = 10;
            end
            if (done) begin
                fin = 1;
                chk("err", err, v.exp_err);
                chk("ncmd", ci, v.exp_ncmd);
                chk("m_beats", mi, nm);
                chk("rd_beats", ri, v.wr ? 0 : int'(v.len) + 1);
                if (v.exp_ncmd == 0) chk("reject_latency", cyc, 0);
                else if (v.wr)       chk("wr_wait_latency", cyc - beat_cyc - 1, v.nack ? 0 : WR);
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) chk("timeout_no_done", 0, 1);
        idle_inputs();
        #1;
        chk("done_one_cycle", {done, busy}, 2'b00);
    endtask

    initial begin
        tbl[0]  = '{1, 8'h10, 3'd1, 64'h5AA5,             0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 8'h10, 3'd2, 64'h332211,           0, 0, 0, 0, 0, 4};
        tbl[2]  = '{1, 8'h06, 3'd2, 64'h0,                0, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 8'h00, 3'd7, 64'h8877665544332211, 0, 0, 1, 0, 0, 1};
        tbl[4]  = '{0, 8'hF8, 3'd7, 64'hF0E0D0C0B0A09080, 0, 0, 1, 0, 0, 9};
        tbl[5]  = '{1, 8'h07, 3'd0, 64'hC3,               0, 0, 0, 0, 0, 1};
        tbl[6]  = '{1, 8'h07, 3'd1, 64'h0,                0, 0, 0, 0, 1, 0};
        tbl[7]  = '{0, 8'h30, 3'd4, 64'h5544332211,       0, 1, 0, 0, 0, 6};
        tbl[8]  = '{1, 8'h20, 3'd0, 64'h77,               1, 0, 0, 0, 1, 1};
        tbl[9]  = '{1, 8'h28, 3'd3, 64'hDDCCBBAA,         0, 0, 0, 1, 0, 1};
        tbl[10] = '{0, 8'h42, 3'd0, 64'h9C,               0, 0, 0, 0, 0, 2};

        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        #1 chk("reset_outputs", ctl_vec(), 0);
        rst = 0;
        @(negedge clk);
        #1 chk("reset_req_ready", req_ready, 1);
        chk("reset_idle_outputs", ctl_vec(), 0);

        for (int i = 0; i < 11; i++) run(tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
